// File: rtl/cheri_dec_pipe.sv
// CHERI decode-to-EX pipe register.
// Holds one decoded CHERI instruction between the decoder and the EX stage.
// Multicycle ops stay resident for McCycles EX handshakes. Non-CHERI
// handshakes are accepted without being captured.

package cheri_pkg;

    // Width of the one-hot decoded CHERI operator vector.
    localparam int unsigned OPDW = 16;

    // Bit position of each decoded operator inside the one-hot vector.
    typedef enum int unsigned {
        OP_CGET_PERM        = 0,
        OP_CGET_TYPE        = 1,
        OP_CGET_BASE        = 2,
        OP_CGET_LEN         = 3,
        OP_CGET_TAG         = 4,
        OP_CGET_TOP         = 5,
        OP_CGET_ADDR        = 6,
        OP_CSEAL            = 7,
        OP_CUNSEAL          = 8,
        OP_CAND_PERM        = 9,
        OP_CSET_ADDR        = 10,
        OP_CINC_ADDR        = 11,
        OP_CSET_BOUNDS      = 12,
        OP_CSET_BOUNDS_EXACT = 13,
        OP_CSPECIAL_RW      = 14,
        OP_CMOVE            = 15
    } cheri_op_e;

    // One-hot operator vector for a single decoded operator.
    function automatic logic [OPDW-1:0] op_onehot(input cheri_op_e op);
        logic [OPDW-1:0] vec;
        vec = '0;
        vec[op] = 1'b1;
        return vec;
    endfunction

endpackage

module cheri_dec_pipe
    import cheri_pkg::*;
#(
    parameter int unsigned McCycles = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    input  logic             instr_is_cheri_i,
    input  logic [OPDW-1:0]  cheri_operator_i,
    input  logic [11:0]      cheri_imm12_i,
    input  logic [19:0]      cheri_imm20_i,
    input  logic [20:0]      cheri_imm21_i,
    input  logic [4:0]       cheri_cs2_dec_i,
    input  logic             cheri_multicycle_i,
    input  logic             flush_i,

    input  logic             ex_ready_i,
    output logic             ex_valid_o,
    output logic [OPDW-1:0]  ex_operator_o,
    output logic [11:0]      ex_imm12_o,
    output logic [19:0]      ex_imm20_o,
    output logic [20:0]      ex_imm21_o,
    output logic [4:0]       ex_cs2_o,
    output logic             ex_first_cycle_o,
    output logic             ex_last_cycle_o,
    output logic             ex_illegal_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_MC    = 2'd2
    } state_e;

    // Counter start value: the op occupies EX for cnt+1 accepted cycles.
    localparam logic [2:0] CntInit = 3'(McCycles - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       first_q, first_d;
    logic       capture;
    logic       complete;
    logic       load;
    logic       clear;
    logic       op_legal;

    assign op_legal = (cheri_operator_i != '0);

    // Handshake, capture/completion detection and next-state selection.
    always_comb begin
        // NOTE: every signal gets a default before the case/if tree so no
        // path leaves it unassigned, which would infer a latch.
        dec_ready_o = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        load        = 1'b0;
        clear       = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            ST_EMPTY: dec_ready_o = 1'b1;
            ST_FULL: begin
                dec_ready_o = ex_ready_i;
                complete    = ex_ready_i;
            end
            ST_MC: begin
                dec_ready_o = ex_ready_i && (cnt_q == 3'd0);
                complete    = ex_ready_i && (cnt_q == 3'd0);
            end
            default: dec_ready_o = 1'b1;
        endcase

        capture = dec_valid_i && dec_ready_o && instr_is_cheri_i && !flush_i;

        if (flush_i) begin
            // Flush wins over everything, including a same-cycle capture.
            state_d = ST_EMPTY;
            cnt_d   = 3'd0;
            first_d = 1'b0;
            clear   = 1'b1;
        end else if (capture) begin
            // Covers both capture from EMPTY and back-to-back after completion.
            load    = 1'b1;
            first_d = 1'b1;
            if (cheri_multicycle_i && op_legal) begin
                state_d = ST_MC;
                cnt_d   = CntInit;
            end else begin
                state_d = ST_FULL;
                cnt_d   = 3'd0;
            end
        end else if (complete) begin
            state_d = ST_EMPTY;
            cnt_d   = 3'd0;
            first_d = 1'b0;
            clear   = 1'b1;
        end else if (state_q == ST_MC && ex_ready_i) begin
            // An intermediate multicycle step: cnt is nonzero here.
            cnt_d   = cnt_q - 3'd1;
            first_d = 1'b0;
        end
    end

    // State, counter and first-cycle flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            cnt_q   <= 3'd0;
            first_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // Payload registers: load on capture, zero on flush or completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the payload is a handful of flops, not a memory, so it is
            // reset; an empty pipe must present all-zero fields.
            ex_operator_o <= '0;
            ex_imm12_o    <= '0;
            ex_imm20_o    <= '0;
            ex_imm21_o    <= '0;
            ex_cs2_o      <= '0;
            ex_illegal_o  <= 1'b0;
        end else if (clear) begin
            ex_operator_o <= '0;
            ex_imm12_o    <= '0;
            ex_imm20_o    <= '0;
            ex_imm21_o    <= '0;
            ex_cs2_o      <= '0;
            ex_illegal_o  <= 1'b0;
        end else if (load) begin
            ex_operator_o <= cheri_operator_i;
            ex_imm12_o    <= cheri_imm12_i;
            ex_imm20_o    <= cheri_imm20_i;
            ex_imm21_o    <= cheri_imm21_i;
            ex_cs2_o      <= cheri_cs2_dec_i;
            ex_illegal_o  <= !op_legal;
        end
    end

    assign ex_valid_o       = (state_q != ST_EMPTY);
    assign ex_first_cycle_o = first_q;
    assign ex_last_cycle_o  = (state_q == ST_FULL) ||
                              ((state_q == ST_MC) && (cnt_q == 3'd0));

endmodule

// File: tb/tb_cheri_dec_pipe.sv
// Self-checking bench for cheri_dec_pipe: scoreboard of captured ops plus
// directed cycle checks of handshake, flags, stall, flush and reset.

module tb_cheri_dec_pipe;
    import cheri_pkg::*;

    localparam int MC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    logic            dec_valid = 1'b0, dec_valid4 = 1'b0;
    logic            is_cheri = 1'b0, multicycle = 1'b0, flush = 1'b0, ex_ready = 1'b1;
    logic [OPDW-1:0] operator_in = '0;
    logic [11:0]     imm12 = '0;
    logic [19:0]     imm20 = '0;
    logic [20:0]     imm21 = '0;
    logic [4:0]      cs2 = '0;

    logic            dec_ready, ex_valid, ex_first, ex_last, ex_illegal;
    logic [OPDW-1:0] ex_op;
    logic [11:0]     ex_imm12;
    logic [19:0]     ex_imm20;
    logic [20:0]     ex_imm21;
    logic [4:0]      ex_cs2;

    logic            d4_ready, d4_valid, d4_first, d4_last, d4_illegal;
    logic [OPDW-1:0] d4_op;
    logic [11:0]     d4_imm12;
    logic [19:0]     d4_imm20;
    logic [20:0]     d4_imm21;
    logic [4:0]      d4_cs2;

    cheri_dec_pipe #(.McCycles(MC)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
        .instr_is_cheri_i(is_cheri), .cheri_operator_i(operator_in),
        .cheri_imm12_i(imm12), .cheri_imm20_i(imm20), .cheri_imm21_i(imm21),
        .cheri_cs2_dec_i(cs2), .cheri_multicycle_i(multicycle), .flush_i(flush),
        .ex_ready_i(ex_ready), .ex_valid_o(ex_valid), .ex_operator_o(ex_op),
        .ex_imm12_o(ex_imm12), .ex_imm20_o(ex_imm20), .ex_imm21_o(ex_imm21),
        .ex_cs2_o(ex_cs2), .ex_first_cycle_o(ex_first), .ex_last_cycle_o(ex_last),
        .ex_illegal_o(ex_illegal)
    );

    cheri_dec_pipe #(.McCycles(4)) dut4 (
        .clk_i(clk), .rst_ni(rst4_n),
        .dec_valid_i(dec_valid4), .dec_ready_o(d4_ready),
        .instr_is_cheri_i(is_cheri), .cheri_operator_i(operator_in),
        .cheri_imm12_i(imm12), .cheri_imm20_i(imm20), .cheri_imm21_i(imm21),
        .cheri_cs2_dec_i(cs2), .cheri_multicycle_i(multicycle), .flush_i(flush),
        .ex_ready_i(ex_ready), .ex_valid_o(d4_valid), .ex_operator_o(d4_op),
        .ex_imm12_o(d4_imm12), .ex_imm20_o(d4_imm20), .ex_imm21_o(d4_imm21),
        .ex_cs2_o(d4_cs2), .ex_first_cycle_o(d4_first), .ex_last_cycle_o(d4_last),
        .ex_illegal_o(d4_illegal)
    );

    typedef struct {
        logic [74:0] pay;     // {op, imm12, imm20, imm21, cs2, illegal}
        int          cycles;  // accepted EX cycles the op must occupy
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ready_cnt = 0;
    int   valid_cycles = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compare the held op against the queue front each EX cycle.
    always @(negedge clk) begin
        if (rst_n && ex_valid) begin
            valid_cycles++;
            if (flush) begin
                if (q.size() > 0) void'(q.pop_front());
                ready_cnt = 0;
            end else if (q.size() == 0) begin
                check("sb_underrun", 80'(q.size()), 80'd1);
            end else begin
                check("sb_payload", {5'd0, ex_op, ex_imm12, ex_imm20, ex_imm21, ex_cs2, ex_illegal},
                      {5'd0, q[0].pay});
                check("sb_first", 80'(ex_first), 80'(ready_cnt == 0));
                check("sb_last", 80'(ex_last), 80'(ready_cnt == q[0].cycles - 1));
                if (ex_ready) begin
                    ready_cnt++;
                    if (ex_last) begin
                        check("sb_ex_cycles", 80'(ready_cnt), 80'(q[0].cycles));
                        void'(q.pop_front());
                        ready_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b0;
    endtask

    // Present one decoded instruction and hold it until the pipe accepts it.
    task automatic send(input logic [OPDW-1:0] op, input logic [11:0] i12,
                        input logic [19:0] i20, input logic [20:0] i21,
                        input logic [4:0] c2, input logic mc, input logic cheri,
                        output int waited);
        logic got;
        exp_t e;
        dec_valid = 1'b1; operator_in = op; imm12 = i12; imm20 = i20;
        imm21 = i21; cs2 = c2; multicycle = mc; is_cheri = cheri;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (dec_ready) got = 1'b1;
            else begin
                step();
                waited++;
            end
        end
        if (!got) check("send_timeout", 80'(got), 80'd1);
        else begin
            if (cheri && !flush) begin
                e.pay    = {op, i12, i20, i21, c2, (op == '0)};
                e.cycles = (mc && op != '0) ? MC : 1;
                q.push_back(e);
            end
            step();
        end
    endtask

    initial begin
        int w, vc0;

        // Reset state.
        @(negedge clk);
        check("rst_dec_ready", 80'(dec_ready), 80'd1);
        check("rst_ex_valid", 80'(ex_valid), 80'd0);
        check("rst_flags", 80'({ex_first, ex_last, ex_illegal}), 80'd0);
        check("rst_payload", 80'({ex_op, ex_imm12, ex_cs2}), 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst4_n = 1'b1;
        step();

        // Single op.
        send(op_onehot(OP_CSET_ADDR), 12'hABC, 20'h0, 21'h0, 5'd3, 1'b0, 1'b1, w);
        idle();
        @(negedge clk);
        check("single_valid", 80'(ex_valid), 80'd1);
        check("single_first_last", 80'({ex_first, ex_last}), 80'b11);
        check("single_imm12", 80'(ex_imm12), 80'hABC);
        step();
        @(negedge clk);
        check("single_empty_valid", 80'(ex_valid), 80'd0);
        check("single_empty_imm12", 80'(ex_imm12), 80'd0);
        step();

        // Multicycle op, McCycles=2.
        send(op_onehot(OP_CSET_BOUNDS), 12'h11, 20'h22, 21'h33, 5'd4, 1'b1, 1'b1, w);
        idle();
        @(negedge clk);
        check("mc_c1_valid", 80'(ex_valid), 80'd1);
        check("mc_c1_first_last", 80'({ex_first, ex_last}), 80'b10);
        check("mc_c1_dec_ready", 80'(dec_ready), 80'd0);
        step();
        @(negedge clk);
        check("mc_c2_valid", 80'(ex_valid), 80'd1);
        check("mc_c2_first_last", 80'({ex_first, ex_last}), 80'b01);
        check("mc_c2_dec_ready", 80'(dec_ready), 80'd1);
        step();
        @(negedge clk);
        check("mc_done_valid", 80'(ex_valid), 80'd0);
        step();

        // Back-to-back single ops.
        vc0 = valid_cycles;
        send(op_onehot(OP_CGET_BASE), 12'h001, 20'h1, 21'h1, 5'd1, 1'b0, 1'b1, w);
        send(op_onehot(OP_CINC_ADDR), 12'h002, 20'h2, 21'h2, 5'd2, 1'b0, 1'b1, w);
        check("b2b_wait2", 80'(w), 80'd0);
        send(op_onehot(OP_CMOVE), 12'h003, 20'h3, 21'h3, 5'd3, 1'b0, 1'b1, w);
        check("b2b_wait3", 80'(w), 80'd0);
        idle();
        @(negedge clk);
        step();
        @(negedge clk);
        check("b2b_valid_cycles", 80'(valid_cycles - vc0), 80'd3);
        step();

        // Multicycle op with EX stalls: counter must hold.
        ex_ready = 1'b0;
        send(op_onehot(OP_CSEAL), 12'h7, 20'h8, 21'h1ABCD, 5'd9, 1'b1, 1'b1, w);
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mcstall_last", 80'({ex_first, ex_last}), 80'b10);
            step();
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("mcstall_rel_c1", 80'({ex_first, ex_last}), 80'b10);
        step();
        @(negedge clk);
        check("mcstall_rel_c2", 80'({ex_first, ex_last}), 80'b01);
        step();

        // Stall in FULL, then flush together with a new decoder op.
        ex_ready = 1'b0;
        send(op_onehot(OP_CAND_PERM), 12'h5A, 20'h12345, 21'h0, 5'd7, 1'b0, 1'b1, w);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_first", 80'(ex_first), 80'd1);
            check("stall_imm20", 80'(ex_imm20), 80'h12345);
            check("stall_dec_ready", 80'(dec_ready), 80'd0);
            step();
        end
        flush = 1'b1; dec_valid = 1'b1; is_cheri = 1'b1;
        operator_in = op_onehot(OP_CMOVE); imm20 = 20'hFFFFF;
        step();
        flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        check("flush_valid", 80'(ex_valid), 80'd0);
        check("flush_payload", 80'({ex_op, ex_imm20, ex_cs2, ex_first}), 80'd0);
        step();

        // Illegal op: multicycle request on an empty operator stays FULL.
        send('0, 12'h0, 20'h0, 21'h0, 5'd0, 1'b1, 1'b1, w);
        idle();
        @(negedge clk);
        check("illegal_flag", 80'(ex_illegal), 80'd1);
        check("illegal_last", 80'(ex_last), 80'd1);
        step();
        @(negedge clk);
        check("illegal_cleared", 80'({ex_valid, ex_illegal}), 80'd0);
        step();

        // Non-CHERI handshake is accepted but not captured.
        send(op_onehot(OP_CGET_TAG), 12'hFFF, 20'h0, 21'h0, 5'd0, 1'b0, 1'b0, w);
        idle();
        @(negedge clk);
        check("noncheri_valid", 80'(ex_valid), 80'd0);
        check("noncheri_ready", 80'(dec_ready), 80'd1);
        step();

        // Reset mid-multicycle on the McCycles=4 instance.
        dec_valid4 = 1'b1; is_cheri = 1'b1; multicycle = 1'b1;
        operator_in = op_onehot(OP_CSET_BOUNDS); imm12 = 12'h55;
        @(negedge clk);
        check("r4_accept", 80'(d4_ready), 80'd1);
        step();
        dec_valid4 = 1'b0;
        @(negedge clk);
        check("r4_c1", 80'({d4_valid, d4_first, d4_last}), 80'b110);
        step();
        @(negedge clk);
        check("r4_c2", 80'({d4_valid, d4_first, d4_last}), 80'b100);
        #1 rst4_n = 1'b0;
        #1;
        check("r4_rst_outputs", 80'({d4_valid, d4_first, d4_last, d4_illegal, d4_imm12, d4_op}), 80'd0);
        check("r4_rst_ready", 80'(d4_ready), 80'd1);
        step();
        rst4_n = 1'b1;
        dec_valid4 = 1'b1; multicycle = 1'b0; imm12 = 12'h66;
        @(negedge clk);
        check("r4_post_ready", 80'(d4_ready), 80'd1);
        step();
        dec_valid4 = 1'b0;
        @(negedge clk);
        check("r4_post_op", 80'({d4_valid, d4_last, d4_imm12}), {66'd0, 1'b1, 1'b1, 12'h66});
        step();

        repeat (3) step();
        check("sb_drained", 80'(q.size()), 80'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
